fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum imem wait cycles before fault.
REQ-002 Parameter EBREAK_WORD, default 32'h0010_0073: instruction encoding that halts fetch.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port PC, input, 32: current PC from the PC register.
REQ-006 Port PC_next, output, 32: next PC value to the PC register.
REQ-007 Port PC_write_en, output, 1: PC register load enable.
REQ-008 Port imem_req, output, 1: instruction memory request.
REQ-009 Port imem_addr, output, 32: instruction address, always equal to PC.
REQ-010 Port imem_ready, input, 1: memory returns imem_rdata this cycle.
REQ-011 Port imem_rdata, input, 32: fetched instruction word.
REQ-012 Port branch_taken, input, 1: redirect request from execute.
REQ-013 Port branch_target, input, 32: redirect address.
REQ-014 Port stall, input, 1: downstream cannot accept the instruction.
REQ-015 Port instr, output, 32: registered instruction to decode.
REQ-016 Port instr_valid, output, 1: instr is valid this cycle.
REQ-017 Port halted, output, 1: fetch stopped (EBREAK or fault).
REQ-018 Port fault, output, 1: halt caused by timeout or misaligned target.
REQ-019 Port retired, output, 32: count of issued instructions.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, ISSUE and HALT.
REQ-021 IDLE SHALL last exactly one cycle after reset deassertion and then go to REQ.
REQ-022 REQ SHALL drive imem_req=1. On imem_ready=1 it SHALL capture imem_rdata into instr and go to ISSUE next cycle.
REQ-023 REQ SHALL increment a wait counter on each cycle with imem_ready=0. When the counter reaches TIMEOUT with ready still low, the FSM SHALL go to HALT with fault=1.
REQ-024 The wait counter SHALL clear on entry to REQ.
REQ-025 ISSUE SHALL drive instr_valid=1. instr_valid SHALL be 0 in every other state.
REQ-026 In ISSUE with stall=1, the FSM SHALL hold ISSUE, keep instr stable and drive PC_write_en=0.
REQ-027 In ISSUE with stall=0, the block SHALL drive PC_write_en=1 for exactly that cycle and increment retired.
- If instr==EBREAK_WORD: go to HALT with fault=0.
- Otherwise: go to REQ.
REQ-028 PC_next SHALL be combinational:
- branch_target when in ISSUE with stall=0 and branch_taken=1.
- Otherwise PC+4, computed modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-029 branch_taken SHALL be ignored in every state other than ISSUE with stall=0.
REQ-030 If branch_taken=1 and branch_target[1:0]!=0 in that cycle, the block SHALL drive PC_write_en=0, leave retired unchanged, and go to HALT with fault=1.
REQ-031 HALT SHALL be absorbing until reset, with halted=1, imem_req=0 and PC_write_en=0.
REQ-032 imem_req SHALL be 1 only in REQ. PC_write_en SHALL be 1 only in ISSUE.
REQ-033 retired SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-034 Asserting reset SHALL immediately force, regardless of clk:
- state=IDLE
- instr=0, instr_valid=0, imem_req=0, PC_write_en=0
- halted=0, fault=0, retired=0
- wait counter=0
REQ-035 Reset asserted mid-REQ or mid-ISSUE SHALL abandon the transaction without emitting PC_write_en.

Verification
REQ-036 Sequential fetch: reset, PC=0, imem_ready=1 every REQ cycle, rdata=32'h0000_0013 -> each fetch takes REQ then ISSUE (2 cycles); PC_next=4, PC_write_en=1 in ISSUE; retired increments by 1 per fetch.
REQ-037 Branch: ISSUE with PC=8, branch_taken=1, branch_target=20 -> PC_next=20, PC_write_en=1; with branch_target=22 instead -> PC_write_en=0, halted=1, fault=1.
REQ-038 Stall: stall=1 for 3 ISSUE cycles -> instr_valid=1 and instr constant throughout, PC_write_en=0; write occurs in the first cycle with stall=0.
REQ-039 Timeout: imem_ready held 0 in REQ -> halted=1, fault=1 after TIMEOUT (15) wait cycles; imem_req=0 afterwards.
REQ-040 EBREAK: rdata=32'h0010_0073 issued -> PC_write_en=1 once, then halted=1, fault=0, retired=1; asserting reset mid-halt clears all outputs at once.
REQ-041 Wrap: ISSUE with PC=32'hFFFF_FFFC and no branch -> PC_next=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory handshake between the fetch controller and imem.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: requests one instruction per PC, issues it to decode,
// then advances or redirects the PC. Halts on EBREAK, imem timeout or misaligned branch.
module fetch_ctrl #(
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [31:0] EBREAK_WORD = 32'h0010_0073
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         PC,
    output logic [31:0]         PC_next,
    output logic                PC_write_en,
    fetch_ctrl_if.master        imem,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                stall,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic                halted,
    output logic                fault,
    output logic [31:0]         retired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_nx;
    logic [31:0]   instr_nx, ret_nx;
    logic          fault_nx;

    assign imem.imem_addr = PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            instr    <= '0;
            fault    <= 1'b0;
            retired  <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            instr    <= instr_nx;
            fault    <= fault_nx;
            retired  <= ret_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        wait_nx       = wait_cnt;
        instr_nx      = instr;
        fault_nx      = fault;
        ret_nx        = retired;
        PC_next       = PC + 32'd4;
        PC_write_en   = 1'b0;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        case (state)
            IDLE: begin
                state_nx = REQ;
                wait_nx  = '0;
            end
            REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) begin
                    instr_nx = imem.imem_rdata;
                    state_nx = ISSUE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = HALT;
                    fault_nx = 1'b1;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    if (branch_taken)
                        PC_next = branch_target;
                    // A misaligned redirect never reaches the PC register.
                    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        state_nx = HALT;
                        fault_nx = 1'b1;
                    end else begin
                        PC_write_en = 1'b1;
                        if (retired != 32'hFFFF_FFFF)
                            ret_nx = retired + 32'd1;
                        if (instr == EBREAK_WORD) begin
                            state_nx = HALT;
                        end else begin
                            state_nx = REQ;
                            wait_nx  = '0;
                        end
                    end
                end
            end
            HALT: halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC writes are scoreboarded by a negedge monitor.
module tb_fetch_ctrl;
    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] PC_next;
    logic        PC_write_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    fetch_ctrl_if imem_bus();

    fetch_ctrl #(.TIMEOUT(15), .EBREAK_WORD(32'h0010_0073)) dut (
        .clk(clk), .reset(reset), .PC(PC), .PC_next(PC_next), .PC_write_en(PC_write_en),
        .imem(imem_bus), .branch_taken(branch_taken), .branch_target(branch_target),
        .stall(stall), .instr(instr), .instr_valid(instr_valid), .halted(halted),
        .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nxt;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (PC_write_en === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pc_write", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pc_next", PC_next, e.nxt);
                    chk("issued_instr", instr, e.ins);
                end
            end
        end
    endtask

    // Asserts reset wherever we are, checks the async clear, releases it and
    // leaves the FSM in REQ at posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_pc_we", {31'd0, PC_write_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        exp_ret = 0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("idle_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        chk("idle_one_cycle", {31'd0, imem_bus.imem_req}, 32'd1);
    endtask

    // Starts in REQ at posedge+1; returns at posedge+1 after the ISSUE that
    // wrote (or refused to write) the PC.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input int stalls,
                         input logic br, input logic [31:0] tgt, input logic [31:0] exp_nxt,
                         input logic writes);
        exp_t e;
        PC = pc;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word;
        #1;
        chk("imem_addr", imem_bus.imem_addr, pc);
        chk("req_in_req", {31'd0, imem_bus.imem_req}, 32'd1);
        step();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = ~word;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            branch_taken = 1'b1;
            branch_target = 32'h0000_0040;
            #1;
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, word);
            chk("stall_no_we", {31'd0, PC_write_en}, 32'd0);
            step();
        end
        stall = 1'b0;
        branch_taken = br;
        branch_target = tgt;
        if (writes) begin
            e.nxt = exp_nxt;
            e.ins = word;
            sb.push_back(e);
            exp_ret = exp_ret + 1;
        end
        #1;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_we", {31'd0, PC_write_en}, {31'd0, writes});
        step();
        branch_taken = 1'b0;
        chk("retired", retired, exp_ret);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        PC = 0;
        branch_taken = 1'b0;
        branch_target = 0;
        stall = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 0;
        fork
            monitor();
        join_none

        // Sequential, branch, stall, wrap, then misaligned redirect.
        do_reset();
        fetch(32'd0,  32'h0000_0013, 0, 1'b0, 32'd0,  32'd4,  1'b1);
        fetch(32'd4,  32'h0000_0013, 0, 1'b0, 32'd0,  32'd8,  1'b1);
        fetch(32'd8,  32'h0050_0093, 0, 1'b1, 32'd20, 32'd20, 1'b1);
        fetch(32'd20, 32'h0000_0013, 3, 1'b0, 32'd0,  32'd24, 1'b1);
        fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("halted_before_fault", {31'd0, halted}, 32'd0);
        fetch(32'd8,  32'h0000_0013, 0, 1'b1, 32'd22, 32'd22, 1'b0);
        chk("misalign_halted", {31'd0, halted}, 32'd1);
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        step();
        step();
        chk("halt_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        // Timeout: ready never rises.
        #2;
        do_reset();
        imem_bus.imem_ready = 1'b0;
        n = 0;
        while (imem_bus.imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("timeout_wait_cycles", n, 32'd15);
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        chk("timeout_fault", {31'd0, fault}, 32'd1);
        step();
        chk("timeout_no_req", {31'd0, imem_bus.imem_req}, 32'd0);

        // EBREAK halts cleanly; reset mid-halt clears at once.
        #2;
        do_reset();
        fetch(32'd0, 32'h0010_0073, 0, 1'b0, 32'd0, 32'd4, 1'b1);
        chk("ebreak_halted", {31'd0, halted}, 32'd1);
        chk("ebreak_fault", {31'd0, fault}, 32'd0);
        chk("ebreak_retired", retired, 32'd1);
        step();
        chk("ebreak_no_we", {31'd0, PC_write_en}, 32'd0);
        chk("ebreak_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
        #2;
        do_reset();

        // Reset mid-REQ, then mid-ISSUE: no PC write may escape.
        imem_bus.imem_ready = 1'b0;
        #2;
        do_reset();
        PC = 32'd16;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h0000_0013;
        step();
        imem_bus.imem_ready = 1'b0;
        stall = 1'b1;
        #2;
        chk("mid_issue_valid", {31'd0, instr_valid}, 32'd1);
        do_reset();
        stall = 1'b0;

        // Recovery after reset.
        fetch(32'd100, 32'h0000_0013, 0, 1'b0, 32'd0, 32'd104, 1'b1);
        step();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
